// File: rtl/bf16_pkg.sv
// Shared BF16 types for the FP32-to-BF16 converter and its result packer.
// A packed pair is two BF16 lanes plus a mask saying which lanes carry data.
package bf16_pkg;

   localparam int BF16_W  = 16;
   localparam int FLAGS_W = 4;

   // Converter fpcsr bit positions
   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [1:0] LANES_FULL  = 2'b11;
   localparam logic [1:0] LANES_FIRST = 2'b01;

   typedef logic [BF16_W-1:0] bf16_t;

   typedef struct packed {
      bf16_t      hi;
      bf16_t      lo;
      logic [1:0] lanes;
   } bf16_pair_t;

endpackage

// File: rtl/bf16_result_packer_if.sv
// Converter-result input stream and packed-word output stream of the packer.
// The packer is the slave; the upstream/downstream environment is the master.
interface bf16_result_packer_if;
   import bf16_pkg::*;

   logic                  in_valid;
   bf16_t                 in_data;
   logic [FLAGS_W-1:0]    in_flags;
   logic                  in_ready;

   logic                  out_valid;
   logic [2*BF16_W-1:0]   out_data;
   logic [1:0]            out_lanes;
   logic                  out_ready;

   modport slave (
      input  in_valid, in_data, in_flags, out_ready,
      output in_ready, out_valid, out_data, out_lanes
   );

   modport master (
      output in_valid, in_data, in_flags, out_ready,
      input  in_ready, out_valid, out_data, out_lanes
   );

endinterface

// File: rtl/bf16_word_fifo.sv
// Synchronous FIFO of packed BF16 pairs; the head entry is shown while non-empty
// and reads as all-zero when empty.
module bf16_word_fifo
   import bf16_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_push,
   input  bf16_pair_t i_wdata,
   input  logic       i_pop,
   output bf16_pair_t o_rdata,
   output logic       o_full,
   output logic       o_empty,
   output logic [AW:0] o_count
);

   bf16_pair_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   // NOTE: storage has no reset; the empty flag masks stale entries, so only
   // pointers and count need clearing.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bf16_result_packer.sv
// Packs consecutive BF16 converter results into 32-bit words, buffers them in a
// small FIFO and keeps sticky exception flags plus a dropped-input overflow bit.
module bf16_result_packer
   import bf16_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LANE_ORDER = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   bf16_result_packer_if.slave  bus,
   input  logic                 flush,
   input  logic                 flags_clear,
   output logic [FLAGS_W-1:0]   acc_flags,
   output logic                 overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic               r_half_valid;
   bf16_t              r_half_data;
   logic               r_flush_pending;
   logic [FLAGS_W-1:0] r_acc_flags;
   logic               r_overflow;

   logic               w_accept;
   logic               w_flush_req;
   logic               w_full;
   logic               w_empty;
   logic               w_has_space;
   logic [CW-1:0]      w_count;
   logic               w_push;
   bf16_pair_t         w_push_word;
   bf16_pair_t         w_head;
   logic               w_half_valid_nxt;
   logic               w_pending_nxt;

   function automatic bf16_pair_t pack_pair(bf16_t first, bf16_t second, logic [1:0] lanes);
      bf16_pair_t p;
      p.hi    = (LANE_ORDER == 0) ? second : first;
      p.lo    = (LANE_ORDER == 0) ? first  : second;
      p.lanes = lanes;
      return p;
   endfunction

   // Ready comes from registered occupancy only, never from out_ready.
   assign bus.in_ready = ~w_full;
   assign w_has_space  = (w_count < CW'(FIFO_DEPTH));
   assign w_accept     = bus.in_valid & ~w_full;
   assign w_flush_req  = flush | r_flush_pending;

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_push           = 1'b0;
      w_push_word      = '0;
      w_half_valid_nxt = r_half_valid;
      w_pending_nxt    = r_flush_pending;
      if (w_accept) begin
         w_pending_nxt = 1'b0;
         if (r_half_valid) begin
            w_push           = 1'b1;
            w_push_word      = pack_pair(r_half_data, bus.in_data, LANES_FULL);
            w_half_valid_nxt = 1'b0;
         end else if (w_flush_req) begin
            w_push      = 1'b1;
            w_push_word = pack_pair(bus.in_data, '0, LANES_FIRST);
         end else begin
            w_half_valid_nxt = 1'b1;
         end
      end else if (r_half_valid && w_flush_req) begin
         // A flush that finds the FIFO full waits for the first free slot
         if (w_has_space) begin
            w_push           = 1'b1;
            w_push_word      = pack_pair(r_half_data, '0, LANES_FIRST);
            w_half_valid_nxt = 1'b0;
            w_pending_nxt    = 1'b0;
         end else begin
            w_pending_nxt = 1'b1;
         end
      end else if (!r_half_valid) begin
         w_pending_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_half_valid    <= 1'b0;
         r_half_data     <= '0;
         r_flush_pending <= 1'b0;
         r_acc_flags     <= '0;
         r_overflow      <= 1'b0;
      end else begin
         r_half_valid    <= w_half_valid_nxt;
         r_flush_pending <= w_pending_nxt;
         if (w_accept && !r_half_valid) r_half_data <= bus.in_data;
         r_acc_flags <= (flags_clear ? '0 : r_acc_flags) | (w_accept ? bus.in_flags : '0);
         r_overflow  <= (bus.in_valid & w_full) | (r_overflow & ~flags_clear);
      end
   end

   bf16_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_wdata (w_push_word),
      .i_pop   (bus.out_ready),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.out_valid = ~w_empty;
   assign bus.out_data  = {w_head.hi, w_head.lo};
   assign bus.out_lanes = w_head.lanes;
   assign acc_flags     = r_acc_flags;
   assign overflow      = r_overflow;

endmodule

// File: tb/tb_bf16_result_packer.sv
// Directed bench for bf16_result_packer (FIFO_DEPTH=4, LANE_ORDER=0) with
// hand-computed expected words, lane masks and flag values.
module tb_bf16_result_packer;
   import bf16_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               flush;
   logic               flags_clear;
   logic [FLAGS_W-1:0] acc_flags;
   logic               overflow;

   int n_compared = 0;
   int n_mismatch = 0;

   bf16_result_packer_if bus ();

   bf16_result_packer #(.FIFO_DEPTH(4), .LANE_ORDER(0)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .flush       (flush),
      .flags_clear (flags_clear),
      .acc_flags   (acc_flags),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatch++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_flags = '0;
      flush        = 1'b0;
      flags_clear  = 1'b0;
   endtask

   task automatic drive(input logic [15:0] data, input logic [3:0] flags);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_flags = flags;
   endtask

   logic [15:0] d [8];

   initial begin
      idle_inputs();
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  bus.out_data,       32'h0);
      check("rst_out_lanes", 32'(bus.out_lanes), 32'd0);
      check("rst_acc_flags", 32'(acc_flags),     32'd0);
      check("rst_overflow",  32'(overflow),      32'd0);
      reset_n = 1'b1;
      step();

      // Pair of consecutive inputs -> one full word one cycle later
      drive(16'h3F80, 4'b0000);
      step();
      check("pair_held_no_word", 32'(bus.out_valid), 32'd0);
      drive(16'h4049, 4'b0000);
      step();
      idle_inputs();
      check("pair_valid", 32'(bus.out_valid), 32'd1);
      check("pair_data",  bus.out_data,       32'h40493F80);
      check("pair_lanes", 32'(bus.out_lanes), 32'd3);
      step();
      check("pair_popped", 32'(bus.out_valid), 32'd0);

      // Single input then flush -> half word in lane 0
      drive(16'hC000, 4'b0000);
      step();
      idle_inputs();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_valid", 32'(bus.out_valid), 32'd1);
      check("flush_data",  bus.out_data,       32'h0000C000);
      check("flush_lanes", 32'(bus.out_lanes), 32'd1);
      step();
      check("flush_popped", 32'(bus.out_valid), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_empty_noop", 32'(bus.out_valid), 32'd0);

      // Accept together with flush, nothing held -> single word
      drive(16'h3F80, 4'b0000);
      flush = 1'b1;
      step();
      idle_inputs();
      check("accfl_single_data",  bus.out_data,       32'h00003F80);
      check("accfl_single_lanes", 32'(bus.out_lanes), 32'd1);
      step();
      check("accfl_single_popped", 32'(bus.out_valid), 32'd0);

      // Accept together with flush while 0x4049 is held -> full word only
      drive(16'h4049, 4'b0000);
      step();
      check("accfl_held_no_word", 32'(bus.out_valid), 32'd0);
      drive(16'h3F80, 4'b0000);
      flush = 1'b1;
      step();
      idle_inputs();
      check("accfl_pair_data",  bus.out_data,       32'h3F804049);
      check("accfl_pair_lanes", 32'(bus.out_lanes), 32'd3);
      step();
      check("accfl_no_extra", 32'(bus.out_valid), 32'd0);
      step();
      check("accfl_no_extra2", 32'(bus.out_valid), 32'd0);

      // Fill the FIFO with the consumer stalled, then overflow and drain
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         d[i] = 16'h1000 + 16'(i);
         drive(d[i], 4'b0000);
         step();
         if (i == 6) check("fill_ready_after7", 32'(bus.in_ready), 32'd1);
      end
      check("fill_ready_after8", 32'(bus.in_ready), 32'd0);
      drive(16'hDEAD, 4'b0100);
      step();
      idle_inputs();
      check("ovf_set",        32'(overflow),  32'd1);
      check("ovf_flags_drop", 32'(acc_flags), 32'd0);
      check("ovf_still_full", 32'(bus.in_ready), 32'd0);
      check("ovf_head_held",  bus.out_data,  {d[1], d[0]});
      bus.out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         check($sformatf("drain%0d_valid", w), 32'(bus.out_valid), 32'd1);
         check($sformatf("drain%0d_data", w),  bus.out_data,       {d[2*w+1], d[2*w]});
         check($sformatf("drain%0d_lanes", w), 32'(bus.out_lanes), 32'd3);
         step();
      end
      check("drain_empty",   32'(bus.out_valid), 32'd0);
      check("drain_ovf_kept", 32'(overflow),     32'd1);
      flags_clear = 1'b1;
      step();
      flags_clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Sticky flags; clear together with an accept yields the new flags
      drive(16'h7FC0, 4'b1000);
      step();
      check("flags_nv", 32'(acc_flags), 32'b1000);
      drive(16'h3F80, 4'b0001);
      flags_clear = 1'b1;
      step();
      idle_inputs();
      check("flags_clear_acc", 32'(acc_flags), 32'b0001);
      check("flags_pair_data", bus.out_data,   32'h3F807FC0);
      step();
      check("flags_sticky", 32'(acc_flags), 32'b0001);

      // Asynchronous reset with two words queued and one held
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(16'h2000 + 16'(i), 4'b0000);
         step();
      end
      idle_inputs();
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_data",  bus.out_data,       32'h0);
      check("async_rst_ready", 32'(bus.in_ready),  32'd1);
      check("async_rst_flags", 32'(acc_flags),     32'd0);
      step();
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      step();
      drive(16'h4110, 4'b0000);
      step();
      idle_inputs();
      check("post_rst_held", 32'(bus.out_valid), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("post_rst_data",  bus.out_data,       32'h00004110);
      check("post_rst_lanes", 32'(bus.out_lanes), 32'd1);
      step();
      check("post_rst_only_one", 32'(bus.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule

// File: doc/bf16_result_packer.md
Name: bf16_result_packer

Overview:
- Downstream stage of the FP32-to-BF16 converter.
- Consumes one registered BF16 result plus its 4-bit fpcsr flags per valid cycle and packs result pairs into 32-bit words.
- Buffers packed words in a small FIFO toward the writeback/store path using a valid/ready handshake.
- Keeps sticky accumulated exception flags and a sticky overflow error for the controller.

Parameters:
FIFO_DEPTH, 4, number of 32-bit packed words buffered; power of 2, at least 2
LANE_ORDER, 0, 0 = first-arriving element goes in [15:0]; 1 = first-arriving element goes in [31:16]

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  converter result valid; the converter's instruction_enable delayed one cycle
in_data  in  16  BF16 result from the converter
in_flags  in  4  converter fpcsr: [3] NV, [2] OF, [1] UF, [0] NX
flush  in  1  single-cycle pulse: emit any pending half word
in_ready  out  1  packer can accept in_valid this cycle
out_valid  out  1  packed word available
out_data  out  32  packed word; 32'h0 when out_valid=0
out_lanes  out  2  lane-valid mask: 2'b11 = full word, 2'b01 = first element only
out_ready  in  1  consumer accepts the word when out_valid=1
acc_flags  out  4  sticky OR of in_flags over all accepted inputs
flags_clear  in  1  clears acc_flags and overflow
overflow  out  1  sticky: in_valid was asserted while in_ready=0; that input is dropped

Behaviour:
- Reset (async assert, sync release): half_valid=0, flush_pending=0, FIFO empty, out_valid=0, out_data=0, out_lanes=0, acc_flags=0, overflow=0, in_ready=1.
- in_ready = !fifo_full, computed from registered count only.
  - A pop in the same cycle does not raise in_ready.
  - Ready does not depend combinationally on out_ready.
- Accept = in_valid & in_ready.
  - If half_valid=0: hold in_data in the half register; set half_valid=1.
  - If half_valid=1: push {in_data, held} (LANE_ORDER=0) with lanes 2'b11; clear half_valid.
- Flush:
  - With half_valid=1 and FIFO not full: push the held element in the first-element lane, other lane 16'h0, lanes 2'b01; clear half_valid.
  - With half_valid=0 and no accept: no-op.
  - With the FIFO full: set flush_pending; perform the flush on the first cycle with space, unless a new accept has completed the pair first, in which case drop flush_pending.
- Accept and flush in the same cycle: the input is applied first, then the flush.
  - half_valid was 0: push the single element, lanes 01.
  - half_valid was 1: push the full word, lanes 11; nothing remains held.
  - At most one push per cycle in all cases.
- FIFO behaviour:
  - Pushed word is visible on out_valid/out_data/out_lanes the next cycle (1-cycle latency, registered).
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
  - out_data and out_lanes hold steady while out_valid=1 and out_ready=0.
- acc_flags:
  - Each cycle: acc_flags <= (flags_clear ? 0 : acc_flags) | (accept ? in_flags : 0).
  - Clear and accept in the same cycle therefore yield in_flags.
- overflow:
  - Set on in_valid & !in_ready.
  - Cleared by flags_clear; set wins over a simultaneous clear.
  - The dropped element does not contribute to acc_flags.
- Reset mid-operation: the held half word, pending flush and all FIFO contents are discarded with no partial output.
- No arithmetic is performed on data; BF16 values pass through bit-exact.

Decomposition:
- Package bf16_pkg:
  - BF16_W=16, FLAGS_W=4
  - Flag indices FLAG_NV=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0
  - typedef bf16_t (logic [15:0])
  - packed struct bf16_pair_t {bf16_t hi; bf16_t lo; logic [1:0] lanes}
  - The converter also adopts this package.
- One sub-module: bf16_word_fifo, a parameterised synchronous FIFO of bf16_pair_t with full/empty/count; same clk/reset_n.
- The packer wraps it with the half register, flush logic and flag logic.

Test Plan:
- Reset, then inputs 0x3F80, 0x4049 on consecutive cycles with out_ready=1 -> one cycle after the second input, out_valid=1, out_data=0x40493F80, out_lanes=2'b11.
- Single input 0xC000, then flush on the next cycle -> out_data=0x0000C000, out_lanes=2'b01; half_valid clear; a further flush produces no word.
- Accept 0x3F80 together with flush while half_valid=0 -> single word 0x00003F80, lanes 01. Repeat with half_valid=1 holding 0x4049 -> word 0x3F804049, lanes 11, no extra word.
- FIFO_DEPTH=4, out_ready=0, 8 inputs -> in_ready falls after the 8th; 9th in_valid sets overflow and is dropped. Then out_ready=1 drains exactly 4 words in order; flags_clear clears overflow.
- Input flags 4'b1000 (NaN), then 4'b0001, with flags_clear asserted alongside the second -> acc_flags=4'b1000, then 4'b0001.
- Assert reset_n low while one word is held and two words are queued -> out_valid=0, out_data=0 immediately (asynchronous). After release, a single input plus flush yields only the new element.
